spi_kick_master: RTL and testbench

- SPI transaction engine that sits on the target side of the KICK/BUSY handshake used by the SPI repeater.
- One rising edge on KICK performs one full-duplex SPI word transfer (mode 0, MSB first) on an external device.
- The block reports BUSY for the whole transaction and presents the received word with a one-cycle valid strobe.
- A repeater-style initiator can chain transfers by pulsing KICK and waiting for BUSY to fall.

---
 rtl/spi_kick_pkg.sv | 27 ++
 rtl/spi_kick_master_bit_timer.sv | 49 ++++
 rtl/spi_kick_master.sv | 138 +++++++++++++
 tb/tb_spi_kick_master.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_kick_pkg.sv
// ============================================================================
// spi_kick_pkg : shared types and helpers for the KICK-driven SPI master
// Revision     : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package spi_kick_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  // Cycles BUSY stays high for one transaction.
  function automatic int total_busy_cycles(input int word_width, input int clk_div,
                                           input int cs_setup, input int cs_hold,
                                           input int cs_gap);
    return cs_setup + 2 * clk_div * word_width + cs_hold + cs_gap;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_kick_master_bit_timer.sv
// ============================================================================
// spi_bit_timer : SCLK rise/fall strobes and bit counting while run is high
// Revision      : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module spi_bit_timer #(
  parameter int WORD_WIDTH = 16,
  parameter int CLK_DIV    = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic run,
  output logic rise,
  output logic fall,
  output logic last_bit
);

  localparam int BW = $clog2(WORD_WIDTH + 1);

  logic [15:0]   r_phase;
  logic          r_high;
  logic [BW-1:0] r_bit;
  logic          w_end;

  assign w_end    = (r_phase == 16'(CLK_DIV - 1));
  assign rise     = run && w_end && !r_high;
  assign fall     = run && w_end && r_high;
  assign last_bit = (r_bit == BW'(WORD_WIDTH - 1));

  // Timer idles at zero outside SHIFT so each word starts with a full low half.
  always_ff @(posedge CLK) begin
    if (RESET || !run) begin
      r_phase <= '0;
      r_high  <= 1'b0;
      r_bit   <= '0;
    end else if (w_end) begin
      r_phase <= '0;
      r_high  <= ~r_high;
      if (r_high) r_bit <= r_bit + 1'b1;
    end else begin
      r_phase <= r_phase + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_kick_master.sv
// ============================================================================
// spi_kick_master : one mode-0 SPI word transfer per rising edge of KICK
// Revision        : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module spi_kick_master
  import spi_kick_pkg::*;
#(
  parameter int WORD_WIDTH = 16,
  parameter int CLK_DIV    = 4,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2,
  parameter int CS_GAP     = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  KICK,
  output logic                  BUSY,
  input  logic [WORD_WIDTH-1:0] TX_DATA,
  output logic [WORD_WIDTH-1:0] RX_DATA,
  output logic                  RX_VALID,
  output logic [15:0]           XFER_COUNT,
  output logic                  SCLK,
  output logic                  MOSI,
  input  logic                  MISO,
  output logic                  CS_N
);

  state_t                r_state;
  logic                  r_kick;
  logic [15:0]           r_cnt;
  logic [WORD_WIDTH-1:0] r_tx;
  logic [WORD_WIDTH-1:0] r_rx;
  logic [WORD_WIDTH-1:0] w_tx_shift;
  logic                  w_rise;
  logic                  w_fall;
  logic                  w_last_bit;

  assign w_tx_shift = r_tx << 1;

  spi_bit_timer #(
    .WORD_WIDTH (WORD_WIDTH),
    .CLK_DIV    (CLK_DIV)
  ) u_bit_timer (
    .CLK      (CLK),
    .RESET    (RESET),
    .run      (r_state == SHIFT),
    .rise     (w_rise),
    .fall     (w_fall),
    .last_bit (w_last_bit)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= IDLE;
      r_kick     <= 1'b1;
      r_cnt      <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      BUSY       <= 1'b0;
      RX_DATA    <= '0;
      RX_VALID   <= 1'b0;
      XFER_COUNT <= '0;
      SCLK       <= 1'b0;
      MOSI       <= 1'b0;
      CS_N       <= 1'b1;
    end else begin
      r_kick   <= KICK;
      RX_VALID <= 1'b0;
      case (r_state)
        IDLE: begin
          if (KICK && !r_kick) begin
            r_state <= SETUP;
            BUSY    <= 1'b1;
            CS_N    <= 1'b0;
            r_tx    <= TX_DATA;
            r_rx    <= '0;
            MOSI    <= TX_DATA[WORD_WIDTH-1];
            r_cnt   <= 16'(CS_SETUP - 1);
          end
        end
        SETUP: begin
          if (r_cnt == 16'd0) r_state <= SHIFT;
          else                r_cnt   <= r_cnt - 16'd1;
        end
        SHIFT: begin
          if (w_rise) begin
            SCLK <= 1'b1;
            r_rx <= (r_rx << 1) | WORD_WIDTH'(MISO);
          end
          // The final falling edge hands the word off instead of shifting.
          if (w_fall) begin
            SCLK <= 1'b0;
            if (w_last_bit) begin
              r_state    <= HOLD;
              r_cnt      <= 16'(CS_HOLD - 1);
              RX_DATA    <= r_rx;
              RX_VALID   <= 1'b1;
              XFER_COUNT <= XFER_COUNT + 16'd1;
            end else begin
              r_tx <= w_tx_shift;
              MOSI <= w_tx_shift[WORD_WIDTH-1];
            end
          end
        end
        HOLD: begin
          if (r_cnt == 16'd0) begin
            r_state <= GAP;
            CS_N    <= 1'b1;
            MOSI    <= 1'b0;
            r_cnt   <= 16'(CS_GAP - 1);
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        GAP: begin
          if (r_cnt == 16'd0) begin
            r_state <= IDLE;
            BUSY    <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          CS_N    <= 1'b1;
          BUSY    <= 1'b0;
          SCLK    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_kick_master.sv
// ============================================================================
// tb_spi_kick_master : directed bench with SPI slave model and scoreboard
// Revision           : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spi_kick_master;
  import spi_kick_pkg::*;

  localparam int WW    = 8;
  localparam int DIV   = 2;
  localparam int SU    = 2;
  localparam int HO    = 2;
  localparam int GA    = 2;
  localparam int TOTAL = total_busy_cycles(WW, DIV, SU, HO, GA);

  typedef struct {
    logic [WW-1:0] tx;
    logic [WW-1:0] rx;
    logic [15:0]   cnt;
  } exp_t;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          KICK = 1'b0;
  logic          MISO = 1'b0;
  logic [WW-1:0] TX_DATA = '0;
  logic          BUSY;
  logic [WW-1:0] RX_DATA;
  logic          RX_VALID;
  logic [15:0]   XFER_COUNT;
  logic          SCLK;
  logic          MOSI;
  logic          CS_N;

  exp_t          sbq[$];
  int            n_pass = 0;
  int            n_total = 0;
  int            busy_cnt = 0;
  int            gap_cnt = 0;
  int            nrise = 0;
  int            n_rxv = 0;
  int            rxv_before;
  logic          prev_busy = 1'b0;
  logic          prev_sclk = 1'b0;
  logic          busy_seen;
  logic [WW-1:0] mosi_acc = '0;
  logic [WW-1:0] miso_word = '0;
  logic [15:0]   exp_cnt = '0;
  logic [WW-1:0] txs [3] = '{8'h01, 8'h80, 8'hFF};

  spi_kick_master #(
    .WORD_WIDTH (WW),
    .CLK_DIV    (DIV),
    .CS_SETUP   (SU),
    .CS_HOLD    (HO),
    .CS_GAP     (GA)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .KICK       (KICK),
    .BUSY       (BUSY),
    .TX_DATA    (TX_DATA),
    .RX_DATA    (RX_DATA),
    .RX_VALID   (RX_VALID),
    .XFER_COUNT (XFER_COUNT),
    .SCLK       (SCLK),
    .MOSI       (MOSI),
    .MISO       (MISO),
    .CS_N       (CS_N)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock; at the falling edge run the slave model and the scoreboard.
  task automatic cycle();
    exp_t e;
    @(negedge CLK);
    if (RESET) begin
      prev_busy = 1'b0;
      prev_sclk = 1'b0;
      return;
    end
    if (BUSY && !prev_busy) begin
      busy_cnt = 0;
      gap_cnt  = 0;
      nrise    = 0;
      mosi_acc = '0;
      MISO     = miso_word[WW-1];
    end
    if (BUSY) begin
      busy_cnt++;
      if (CS_N) gap_cnt++;
    end
    if (SCLK && !prev_sclk) begin
      mosi_acc = {mosi_acc[WW-2:0], MOSI};
      nrise++;
      MISO = (nrise < WW) ? miso_word[WW-1-nrise] : 1'b0;
    end
    if (RX_VALID) begin
      n_rxv++;
      if (sbq.size() == 0) begin
        chk("rx_valid_unexpected", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("rx_data", 32'(RX_DATA), 32'(e.rx));
        chk("mosi_bits", 32'(mosi_acc), 32'(e.tx));
        chk("sclk_pulses", 32'(nrise), 32'(WW));
        chk("xfer_count", 32'(XFER_COUNT), 32'(e.cnt));
      end
    end
    if (!BUSY && prev_busy) begin
      chk("busy_width", 32'(busy_cnt), 32'(TOTAL));
      chk("cs_gap", 32'(gap_cnt), 32'(GA));
    end
    prev_busy = BUSY;
    prev_sclk = SCLK;
  endtask

  task automatic push_exp(input logic [WW-1:0] tx, input logic [WW-1:0] rx);
    exp_cnt = exp_cnt + 16'd1;
    sbq.push_back('{tx: tx, rx: rx, cnt: exp_cnt});
  endtask

  task automatic kick_pulse(input logic [WW-1:0] tx, input logic [WW-1:0] rx);
    miso_word = rx;
    TX_DATA   = tx;
    push_exp(tx, rx);
    KICK = 1'b1;
    cycle();
    chk("busy_after_kick", 32'(BUSY), 32'd1);
    KICK = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (BUSY && n < max) begin
      cycle();
      n++;
    end
    if (BUSY) chk("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) cycle();
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_cs_n", 32'(CS_N), 32'd1);
    chk("rst_sclk", 32'(SCLK), 32'd0);
    chk("rst_mosi", 32'(MOSI), 32'd0);
    chk("rst_rx_data", 32'(RX_DATA), 32'd0);
    chk("rst_rx_valid", 32'(RX_VALID), 32'd0);
    chk("rst_xfer_count", 32'(XFER_COUNT), 32'd0);
    RESET = 1'b0;
    cycle();

    // 1: basic transfer
    kick_pulse(8'hA5, 8'h3C);
    wait_idle(200);
    chk("t1_count", 32'(XFER_COUNT), 32'd1);

    // 2: KICK held high gives a single transfer
    miso_word = 8'h34;
    TX_DATA   = 8'h12;
    push_exp(8'h12, 8'h34);
    KICK = 1'b1;
    repeat (100) cycle();
    chk("t2_held_count", 32'(XFER_COUNT), 32'(exp_cnt));
    chk("t2_held_idle", 32'(BUSY), 32'd0);
    KICK = 1'b0;
    cycle();
    kick_pulse(8'h69, 8'hE7);
    wait_idle(200);
    chk("t2_count", 32'(XFER_COUNT), 32'(exp_cnt));

    // 3: extra KICK edge during SHIFT is ignored
    rxv_before = n_rxv;
    kick_pulse(8'hC3, 8'h99);
    repeat (6) cycle();
    KICK = 1'b1;
    cycle();
    KICK = 1'b0;
    cycle();
    KICK = 1'b1;
    cycle();
    KICK = 1'b0;
    wait_idle(200);
    repeat (5) cycle();
    chk("t3_one_rx_valid", 32'(n_rxv - rxv_before), 32'd1);
    chk("t3_no_requeue", 32'(BUSY), 32'd0);

    // 4: back-to-back repeater kicks, loopback MISO
    for (int i = 0; i < 3; i++) begin
      kick_pulse(txs[i], txs[i]);
      wait_idle(200);
    end
    chk("t4_count", 32'(XFER_COUNT), 32'(exp_cnt));
    chk("t4_sb_empty", 32'(sbq.size()), 32'd0);

    // 5: reset during SHIFT, then KICK high through reset release
    kick_pulse(8'hF0, 8'h0F);
    repeat (11) cycle();
    RESET = 1'b1;
    KICK  = 1'b1;
    cycle();
    chk("t5_cs_n", 32'(CS_N), 32'd1);
    chk("t5_sclk", 32'(SCLK), 32'd0);
    chk("t5_busy", 32'(BUSY), 32'd0);
    chk("t5_count", 32'(XFER_COUNT), 32'd0);
    chk("t5_rx_valid", 32'(RX_VALID), 32'd0);
    void'(sbq.pop_back());
    exp_cnt = '0;
    RESET = 1'b0;
    busy_seen = 1'b0;
    repeat (20) begin
      cycle();
      if (BUSY) busy_seen = 1'b1;
    end
    chk("t5_no_start", 32'(busy_seen), 32'd0);
    KICK = 1'b0;
    cycle();
    kick_pulse(8'h5A, 8'hC3);
    wait_idle(200);
    chk("t5_count_after", 32'(XFER_COUNT), 32'd1);

    // 6: counter wraps from 0xFFFF to 0
    cycle();
    force dut.XFER_COUNT = 16'hFFFF;
    #1;
    release dut.XFER_COUNT;
    exp_cnt = 16'hFFFF;
    cycle();
    chk("t6_preload", 32'(XFER_COUNT), 32'hFFFF);
    kick_pulse(8'h81, 8'h7E);
    wait_idle(200);
    chk("t6_wrap", 32'(XFER_COUNT), 32'd0);
    chk("t6_sb_empty", 32'(sbq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
